// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the fetch unit (if_*) and
//   the load/store unit (d_*). A request seen in IDLE is captured, presented on
//   mem_* until mem_ready, then acknowledged to its owner for one cycle with
//   registered read data. Data wins ties by default.
//
//   Optional build macro: ARB_STARVE_GUARD_EN
//     When defined, a run counter limits consecutive data grants made while
//     fetch is waiting to MAX_DATA_RUN; after that, fetch is granted once.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   if_req/if_addr    fetch request (held until if_ack)
//   if_ack/if_rdata   fetch completion pulse + fetched word
//   d_req/d_we/d_be/d_addr/d_wdata   data request (held until d_ack)
//   d_ack/d_rdata     data completion pulse + load data
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   memory access (from captured regs)
//   mem_rdata/mem_ready                        memory response
//   stall             combinational: a requester is still waiting
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_ack,
  output logic [DW-1:0]     if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DW/8-1:0]   d_be,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_ack,
  output logic [DW-1:0]     d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DW/8-1:0]   mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ready,
  output logic              stall
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, RESP} state_t;

  state_t          state, state_nxt;
  logic            grant_d, grant_if;
  logic            guard_trip;
  logic            owner_d;
  logic            cap_we;
  logic [BW-1:0]   cap_be;
  logic [AW-1:0]   cap_addr;
  logic [DW-1:0]   cap_wdata;

  // Memory side is driven only from the capture registers so the requester
  // ports may change freely once the access has been granted.
  assign mem_req   = (state == GNT_IF) || (state == GNT_D);
  assign mem_we    = mem_req & cap_we;
  assign mem_be    = cap_be;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;

  assign if_ack = (state == RESP) && !owner_d;
  assign d_ack  = (state == RESP) &&  owner_d;
  assign stall  = (if_req & ~if_ack) | (d_req & ~d_ack);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_DATA_RUN + 1);

  // Counts data grants made back-to-back while fetch was waiting.
  logic [CW-1:0] run_cnt;

  assign guard_trip = if_req && (run_cnt == CW'(MAX_DATA_RUN));

  always_ff @(posedge clk) begin
    if (!rst)                              run_cnt <= '0;
    else if (grant_if || (grant_d && !if_req)) run_cnt <= '0;
    else if (grant_d)                      run_cnt <= run_cnt + 1'b1;
  end
`else
  assign guard_trip = 1'b0;
  logic unused_run_cfg;
  assign unused_run_cfg = (MAX_DATA_RUN > 0);
`endif

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !guard_trip) begin
          grant_d   = 1'b1;
          state_nxt = GNT_D;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = GNT_IF;
        end
      end
      GNT_IF, GNT_D: if (mem_ready) state_nxt = RESP;
      RESP:          state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        cap_we    <= d_we;
        cap_be    <= d_be;
        cap_addr  <= d_addr;
        cap_wdata <= d_wdata;
      end else if (grant_if) begin
        // Fetch is always a full-word read; wdata keeps its stale value.
        cap_we   <= 1'b0;
        cap_be   <= '1;
        cap_addr <= if_addr;
      end
      if (mem_req && mem_ready) begin
        owner_d <= (state == GNT_D);
        if (state == GNT_D) d_rdata  <= mem_rdata;
        else                if_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = DW / 8, MAX_RUN = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0, rst = 1'b0;
  logic            if_req = 0, if_ack;
  logic [AW-1:0]   if_addr = 0;
  logic [DW-1:0]   if_rdata;
  logic            d_req = 0, d_we = 0, d_ack;
  logic [BW-1:0]   d_be = 0;
  logic [AW-1:0]   d_addr = 0;
  logic [DW-1:0]   d_wdata = 0, d_rdata;
  logic            mem_req, mem_we, mem_ready = 0, stall;
  logic [BW-1:0]   mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata = 0;

  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall)
  );

  // Inputs change only just after a falling edge; outputs are sampled there too.
  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0;
    d_wdata = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 0; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; idle_inputs();
    repeat (2) @(negedge clk);
    n_run++; if ({mem_req, mem_we, if_ack, d_ack, stall} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl got=%b exp=00000", {mem_req, mem_we, if_ack, d_ack, stall}); end
    n_run++; if ({mem_be, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mem got=%h exp=0", {mem_be, mem_addr, mem_wdata}); end
    n_run++; if ({if_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata}); end
    rst = 1;
    @(negedge clk);
    n_run++; if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h100;
    #1;
    n_run++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall0 got=%b exp=1", stall); end
    @(negedge clk);
    n_run++; if ({mem_req, mem_we, mem_be} !== {1'b1, 1'b0, 4'hF}) begin
      n_fail++; $display("FAIL fetch_gnt got=%b exp=101111", {mem_req, mem_we, mem_be}); end
    n_run++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_addr got=%h exp=100", mem_addr); end
    n_run++; if ({stall, if_ack} !== 2'b10) begin n_fail++; $display("FAIL fetch_stall1 got=%b exp=10", {stall, if_ack}); end
    mem_ready = 1; mem_rdata = 32'h00A00093;
    @(negedge clk);
    n_run++; if ({if_ack, d_ack, mem_req, stall} !== 4'b1000) begin
      n_fail++; $display("FAIL fetch_ack got=%b exp=1000", {if_ack, d_ack, mem_req, stall}); end
    n_run++; if (if_rdata !== 32'h00A00093) begin n_fail++; $display("FAIL fetch_rdata got=%h exp=00a00093", if_rdata); end
    if_req = 0; mem_ready = 0; mem_rdata = 0;
    @(negedge clk);
    n_run++; if ({if_ack, mem_req} !== 2'b00) begin n_fail++; $display("FAIL fetch_done got=%b exp=00", {if_ack, mem_req}); end
  endtask

  task automatic test_store_wait();
    do_reset();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hCAFE1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin d_addr = 32'hDEAD0000; d_wdata = 32'h0; d_be = 4'hC; end // ports wiggle; mem_* must not
      n_run++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hCAFE1234}) begin
        n_fail++; $display("FAIL store_hold%0d got=%h exp=%h", i, {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
                           {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hCAFE1234}); end
      n_run++; if (d_ack !== 1'b0) begin n_fail++; $display("FAIL store_early_ack%0d got=%b exp=0", i, d_ack); end
    end
    mem_ready = 1; mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    n_run++; if ({d_ack, if_ack, mem_req} !== 3'b100) begin
      n_fail++; $display("FAIL store_ack got=%b exp=100", {d_ack, if_ack, mem_req}); end
    idle_inputs();
    @(negedge clk);
    n_run++; if (d_ack !== 1'b0) begin n_fail++; $display("FAIL store_ack_pulse got=%b exp=0", d_ack); end
  endtask

  task automatic test_contention();
    int run = 0, acks = 0, cyc = 0;
    bit exp_d;
    do_reset();
    if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h80; d_we = 0; d_be = 4'hF;
    while (acks < 15 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (if_ack || d_ack) begin
        exp_d = !(GUARD && run == MAX_RUN);
        n_run++; if ({d_ack, if_ack} !== {exp_d, !exp_d}) begin
          n_fail++; $display("FAIL contend_grant%0d got=%b exp=%b", acks, {d_ack, if_ack}, {exp_d, !exp_d}); end
        run = exp_d ? run + 1 : 0;
        acks++;
      end
      mem_ready = mem_req; mem_rdata = $urandom;
    end
    n_run++; if (acks < 15) begin n_fail++; $display("FAIL contend_timeout got=%0d exp=15", acks); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    bit got = 0;
    do_reset();
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h3000; d_wdata = 32'h12345678;
    @(negedge clk);
    n_run++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt got=%b exp=1", mem_req); end
    rst = 0; d_req = 0; mem_ready = 1;
    @(negedge clk);
    n_run++; if ({mem_req, mem_we, if_ack, d_ack, mem_be, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL rstmid_zero got=%h exp=0", {mem_req, mem_we, if_ack, d_ack, mem_be, mem_addr, mem_wdata}); end
    rst = 1; mem_ready = 0;
    @(negedge clk);
    n_run++; if (d_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_noack got=%b exp=0", d_ack); end
    if_req = 1; if_addr = 32'h200;
    while (!got && cyc < 20) begin
      @(negedge clk); cyc++;
      if (if_ack) begin
        got = 1;
        n_run++; if (if_rdata !== 32'hBEEF0200) begin
          n_fail++; $display("FAIL rstmid_fetch_rdata got=%h exp=beef0200", if_rdata); end
        if_req = 0;
      end
      mem_ready = mem_req && (mem_addr == 32'h200); mem_rdata = 32'hBEEF0200;
    end
    n_run++; if (!got) begin n_fail++; $display("FAIL rstmid_fetch_timeout got=0 exp=1"); end
    idle_inputs();
    @(negedge clk);
  endtask

  // Transaction-level scoreboard: an access is "in flight" from the grant until
  // memory reports ready, then its owner is "due" exactly one ack next cycle.
  task automatic test_random();
    bit in_flight = 0, due = 0, own_d = 0;
    bit e_we = 0;
    logic [BW-1:0] e_be = 0;
    logic [AW-1:0] e_addr = 0;
    logic [DW-1:0] e_wd = 0, e_rd = 0;
    int run = 0, n_ready = 0, n_ack = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      // account for what the posedge just passed saw
      if (due) due = 0;
      else if (in_flight) begin
        if (mem_ready) begin in_flight = 0; due = 1; e_rd = mem_rdata; n_ready++; end
      end else if (d_req && !(GUARD && if_req && run == MAX_RUN)) begin
        in_flight = 1; own_d = 1; e_we = d_we; e_be = d_be; e_addr = d_addr; e_wd = d_wdata;
        run = if_req ? run + 1 : 0;
      end else if (if_req) begin
        in_flight = 1; own_d = 0; e_we = 0; e_be = '1; e_addr = if_addr; run = 0;
      end
      n_run++; if (mem_req !== in_flight) begin
        n_fail++; $display("FAIL rnd_req c%0d got=%b exp=%b", cyc, mem_req, in_flight); end
      if (in_flight) begin
        n_run++; if ({mem_we, mem_be, mem_addr} !== {e_we, e_be, e_addr} || (e_we && mem_wdata !== e_wd)) begin
          n_fail++; $display("FAIL rnd_mem c%0d got=%h exp=%h", cyc, {mem_we, mem_be, mem_addr, mem_wdata},
                             {e_we, e_be, e_addr, e_wd}); end
      end
      n_run++; if ({if_ack, d_ack} !== {due && !own_d, due && own_d}) begin
        n_fail++; $display("FAIL rnd_ack c%0d got=%b exp=%b", cyc, {if_ack, d_ack}, {due && !own_d, due && own_d}); end
      n_run++; if (if_ack && d_ack) begin n_fail++; $display("FAIL rnd_both_ack c%0d got=11 exp=not11", cyc); end
      if (due) begin
        n_run++; if ((own_d ? d_rdata : if_rdata) !== e_rd) begin
          n_fail++; $display("FAIL rnd_rdata c%0d got=%h exp=%h", cyc, own_d ? d_rdata : if_rdata, e_rd); end
      end
      n_run++; if (stall !== ((if_req & ~if_ack) | (d_req & ~d_ack))) begin
        n_fail++; $display("FAIL rnd_stall c%0d got=%b", cyc, stall); end
      if (if_ack || d_ack) n_ack++;
      // drive next cycle
      if (if_req && if_ack) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      if (d_req && d_ack) d_req = 0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_be = $urandom; d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = mem_req && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end
    @(negedge clk);
    if (due) n_ack += (if_ack || d_ack) ? 1 : 0;
    n_run++; if (n_ack !== n_ready || n_ready < 50) begin
      n_fail++; $display("FAIL rnd_ready_vs_ack got=%0d acks exp=%0d readies", n_ack, n_ready); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wait();
    test_contention();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
